// File: rtl/sccb_slave.sv
// sccb_slave
// SCCB/I2C-compatible register target. The bus pins are oversampled with clk
// (at least 16x the scl rate). The block decodes 3-phase writes (device,
// register, data...) and 2-phase write + 2-phase read cycles, and maps them
// onto a synchronous register-file port.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   scl        bus clock from the master (asynchronous to clk)
//   sda        open-drain bus data; this block only drives 0 or z
//   reg_addr   register pointer (auto-increments after each data byte)
//   reg_wdata  write data, valid while reg_wr is high
//   reg_wr     one-clk write strobe
//   reg_rd     one-clk read strobe
//   reg_rdata  read data, valid on the clk after reg_rd
//   busy       high from START to STOP, dropped early on an address mismatch
`timescale 1ns/1ps

module sccb_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE
  } state_t;

  state_t     state, next_state;
  logic [2:0] scl_sync, sda_sync;   // [1:0] synchronizer, [2] previous value
  logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] byte_in;
  logic       rw, sda_oe, rd_req, rd_cap;
  logic       in_rx, in_ack, byte_done, ack_begin, ack_end, addr_match;

  // Input conditioning
  // NOTE: the synchronizers reset to the idle bus level (high) so that leaving
  // reset can never look like a START, STOP or scl edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], scl};
      sda_sync <= {sda_sync[1:0], sda};
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  =  scl_sync[1] & ~scl_sync[2];
  assign scl_fall  = ~scl_sync[1] &  scl_sync[2];
  assign start_det =  scl_s & scl_sync[2] & ~sda_s &  sda_sync[2];
  assign stop_det  =  scl_s & scl_sync[2] &  sda_s & ~sda_sync[2];

  assign byte_in    = {shift[6:0], sda_s};
  assign addr_match = (shift[6:0] == DEV_ADDR);
  assign byte_done  = in_rx  && scl_rise && (bit_cnt == 4'd7);
  // Inside an ACK slot sda_oe doubles as "ACK already driven": the first scl
  // fall asserts it, the second one ends the slot.
  assign ack_begin  = in_ack && scl_fall && !sda_oe;
  assign ack_end    = in_ack && scl_fall &&  sda_oe;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM: next state
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    if (start_det) begin
      next_state = DEV;
    end else if (stop_det) begin
      next_state = IDLE;
    end else begin
      case (state)
        DEV:       if (byte_done) next_state = addr_match ? DEV_ACK : IGNORE;
        DEV_ACK:   if (ack_end)   next_state = rw ? RDATA : REG;
        REG:       if (byte_done) next_state = REG_ACK;
        REG_ACK:   if (ack_end)   next_state = WDATA;
        WDATA:     if (byte_done) next_state = WDATA_ACK;
        WDATA_ACK: if (ack_end)   next_state = WDATA;
        RDATA:     if (scl_fall && bit_cnt == 4'd8) next_state = RD_MACK;
        RD_MACK:   if (scl_rise)  next_state = sda_s ? IGNORE : RDATA;
        default:   next_state = state;
      endcase
    end
  end

  // FSM: state decodes
  always_comb begin
    in_rx  = 1'b0;
    in_ack = 1'b0;
    case (state)
      DEV, REG, WDATA:             in_rx  = 1'b1;
      DEV_ACK, REG_ACK, WDATA_ACK: in_ack = 1'b1;
      default: ;
    endcase
  end

  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Datapath: shift register, bit counter, pointer, strobes, sda drive
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shift     <= '0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      rd_req    <= 1'b0;
      rd_cap    <= 1'b0;
      busy      <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= rd_req;        // read after a master ACK waits for the new pointer
      rd_req <= 1'b0;
      rd_cap <= reg_rd;        // reg_rdata is valid the clk after reg_rd
      if (rd_cap) shift <= reg_rdata;
      if (reg_wr) reg_addr <= reg_addr + 8'd1;

      if (start_det) begin
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_det) begin
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        if (in_rx && scl_rise) begin
          shift   <= byte_in;
          bit_cnt <= bit_cnt + 4'd1;
          if (byte_done) begin
            bit_cnt <= '0;
            case (state)
              DEV: begin
                if (addr_match) begin
                  rw     <= sda_s;
                  reg_rd <= sda_s;
                end else begin
                  busy <= 1'b0;
                end
              end
              REG: reg_addr <= byte_in;
              default: begin
                reg_wdata <= byte_in;
                reg_wr    <= 1'b1;
              end
            endcase
          end
        end

        if (ack_begin) sda_oe <= 1'b1;

        if (ack_end) begin
          if (state == DEV_ACK && rw) begin
            // The fall that ends the ACK also presents the first data bit.
            sda_oe  <= ~shift[7];
            shift   <= {shift[6:0], 1'b0};
            bit_cnt <= 4'd1;
          end else begin
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
          end
        end

        if (state == RDATA && scl_fall) begin
          if (bit_cnt == 4'd8) begin
            sda_oe <= 1'b0;    // hand sda to the master for its ACK/NACK
          end else begin
            sda_oe  <= ~shift[7];
            shift   <= {shift[6:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        if (state == RD_MACK && scl_rise && !sda_s) begin
          reg_addr <= reg_addr + 8'd1;
          rd_req   <= 1'b1;
          bit_cnt  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sccb_slave.sv
// tb_sccb_slave
// Directed bench for sccb_slave: a bit-banged SCCB master, a small register
// file model behind reg_*, and monitors that log write/read strobes and any
// low level on sda that the master is not causing.
`timescale 1ns/1ps

module tb_sccb_slave;

  localparam time Q = 50ns;   // quarter scl period (scl = 1/20 of clk rate)

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m;
  logic       m_sda_low;
  wire        sda;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr, reg_rd, busy;

  logic [7:0]  mem [256];
  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];
  int          drv_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  sccb_slave #(.DEV_ADDR(7'h21)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl_m),
    .sda       (sda),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  // Register file model: read data appears the clk after reg_rd.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[8'h0A] <= 8'h76;
      mem[8'h0B] <= 8'hC3;
    end else begin
      if (reg_wr) mem[reg_addr] <= reg_wdata;
      if (reg_rd) reg_rdata <= mem[reg_addr];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_wr) wr_q.push_back({reg_addr, reg_wdata});
      if (reg_rd) rd_q.push_back(reg_addr);
      if (sda === 1'b0 && !m_sda_low) drv_cnt++;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] wr_at(input int i);
    if (i < wr_q.size()) return wr_q[i];
    return 16'hxxxx;
  endfunction

  function automatic logic [7:0] rd_at(input int i);
    if (i < rd_q.size()) return rd_q[i];
    return 8'hxx;
  endfunction

  // Bit slot: starts just after an scl fall, ends with the next scl fall.
  task automatic bit_slot(input logic b, output logic seen);
    #Q m_sda_low = ~b;
    #Q scl_m = 1'b1;
    #Q seen = sda;
    #Q scl_m = 1'b0;
  endtask

  task automatic bus_start;
    #Q m_sda_low = 1'b0;
    #Q scl_m = 1'b1;
    #Q m_sda_low = 1'b1;
    #Q scl_m = 1'b0;
  endtask

  task automatic bus_stop;
    #Q m_sda_low = 1'b1;
    #Q scl_m = 1'b1;
    #Q m_sda_low = 1'b0;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_slot(b[i], s);
    bit_slot(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] b);
    logic s;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      bit_slot(1'b1, s);
      b = {b[6:0], s};
    end
    bit_slot(~master_ack, s);
  endtask

  initial begin
    logic       a0, a1, a2, a3;
    logic       s;
    logic [7:0] d0, d1;
    logic [7:0] addr_byte;
    int         wb, rb, db;

    scl_m     = 1'b1;
    m_sda_low = 1'b0;
    rst_n     = 1'b0;

    // Reset values
    #33;
    check("rst_sda", sda, 1'b1);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    check("rst_reg_wr", reg_wr, 1'b0);
    check("rst_reg_rd", reg_rd, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    #Q;

    // 1: 3-phase write
    wb = wr_q.size();
    bus_start;
    check("t1_busy_start", busy, 1'b1);
    send_byte(8'h42, a0);
    send_byte(8'h12, a1);
    send_byte(8'h80, a2);
    bus_stop;
    check("t1_acks", {a0, a1, a2}, 3'b111);
    check("t1_wr_cnt", wr_q.size() - wb, 1);
    check("t1_wr0", wr_at(wb), 16'h1280);
    check("t1_busy_end", busy, 1'b0);
    check("t1_addr_inc", reg_addr, 8'h13);

    // 2: pointer write, then read with NACK
    wb = wr_q.size();
    rb = rd_q.size();
    bus_start;
    send_byte(8'h42, a0);
    send_byte(8'h0A, a1);
    bus_stop;
    check("t2_ptr", reg_addr, 8'h0A);
    bus_start;
    send_byte(8'h43, a2);
    recv_byte(1'b0, d0);
    bus_stop;
    check("t2_acks", {a0, a1, a2}, 3'b111);
    check("t2_rd_cnt", rd_q.size() - rb, 1);
    check("t2_rd_addr", rd_at(rb), 8'h0A);
    check("t2_data", d0, 8'h76);
    check("t2_no_wr", wr_q.size() - wb, 0);
    check("t2_addr_kept", reg_addr, 8'h0A);
    check("t2_busy", busy, 1'b0);
    check("t2_sda", sda, 1'b1);

    // 3: address mismatch
    wb = wr_q.size();
    db = drv_cnt;
    bus_start;
    send_byte(8'h60, a0);
    check("t3_busy", busy, 1'b0);
    check("t3_nack", a0, 1'b0);
    send_byte(8'h55, a1);
    send_byte(8'hAA, a2);
    bus_stop;
    check("t3_never_driven", drv_cnt - db, 0);
    check("t3_no_wr", wr_q.size() - wb, 0);

    // 4: burst across the pointer wrap
    wb = wr_q.size();
    bus_start;
    send_byte(8'h42, a0);
    send_byte(8'hFF, a1);
    send_byte(8'h11, a2);
    send_byte(8'h22, a3);
    bus_stop;
    check("t4_acks", {a0, a1, a2, a3}, 4'hF);
    check("t4_wr_cnt", wr_q.size() - wb, 2);
    check("t4_wr0", wr_at(wb), 16'hFF11);
    check("t4_wr1", wr_at(wb + 1), 16'h0022);
    check("t4_addr", reg_addr, 8'h01);

    // 5: STOP after 4 bits of the register byte, then a clean write
    wb = wr_q.size();
    rb = rd_q.size();
    addr_byte = 8'hA0;
    bus_start;
    send_byte(8'h42, a0);
    for (int i = 7; i >= 4; i--) bit_slot(addr_byte[i], s);
    bus_stop;
    check("t5_no_wr", wr_q.size() - wb, 0);
    check("t5_no_rd", rd_q.size() - rb, 0);
    check("t5_addr_kept", reg_addr, 8'h01);
    check("t5_sda", sda, 1'b1);
    check("t5_busy", busy, 1'b0);
    bus_start;
    send_byte(8'h42, a0);
    send_byte(8'h33, a1);
    send_byte(8'h5A, a2);
    bus_stop;
    check("t5_acks", {a0, a1, a2}, 3'b111);
    check("t5_wr_cnt", wr_q.size() - wb, 1);
    check("t5_wr0", wr_at(wb), 16'h335A);

    // 6: reset while the block holds sda low, then repeated-START read
    bus_start;
    send_byte(8'h42, a0);
    send_byte(8'h0A, a1);
    bus_stop;
    addr_byte = 8'h43;
    bus_start;
    for (int i = 7; i >= 0; i--) bit_slot(addr_byte[i], s);
    #Q m_sda_low = 1'b0;
    #Q scl_m = 1'b1;
    #Q;
    check("t6_ack_low", sda, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_sda", sda, 1'b1);
    check("t6_rst_addr", reg_addr, 8'h00);
    check("t6_rst_wdata", reg_wdata, 8'h00);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_wr", reg_wr, 1'b0);
    check("t6_rst_rd", reg_rd, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #2;
    scl_m = 1'b0;
    rb = rd_q.size();
    bus_start;
    send_byte(8'h42, a0);
    send_byte(8'h0A, a1);
    bus_start;
    send_byte(8'h43, a2);
    recv_byte(1'b1, d0);
    recv_byte(1'b0, d1);
    bus_stop;
    check("t6_acks", {a0, a1, a2}, 3'b111);
    check("t6_data0", d0, 8'h76);
    check("t6_data1", d1, 8'hC3);
    check("t6_rd_cnt", rd_q.size() - rb, 2);
    check("t6_rd_addr0", rd_at(rb), 8'h0A);
    check("t6_rd_addr1", rd_at(rb + 1), 8'h0B);
    check("t6_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
